// File: rtl/uart_axi_sched_if.sv
// AXI4-lite link between uart_axi_sched (master) and the UART register block (slave).
interface uart_axi_sched_if;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/uart_axi_sched.sv
// Shares the AXI4-lite UART port between an RX byte client and a TX client with round-robin
// arbitration and status polling. Define UART_SCHED_WORD_EN for 32-bit TX words sent as 4 bytes.
module uart_axi_sched #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_req,
  output logic        rx_ack,
  output logic [7:0]  rx_data,
  input  logic        tx_req,
`ifdef UART_SCHED_WORD_EN
  input  logic [31:0] tx_data,
`else
  input  logic [7:0]  tx_data,
`endif
  output logic        tx_ack,
  output logic        busy,
  output logic        err,
  uart_axi_sched_if.master uart_axi
);

  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic       GNT_RX    = 1'b0;
  localparam logic       GNT_TX    = 1'b1;
  localparam logic [7:0] GAP_LOAD  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, ST_AR, ST_R, RX_AR, RX_R, TX_W, TX_B, BACKOFF
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  gap_q, gap_d;
  logic        arvalid_q, arvalid_d;
  logic [3:0]  araddr_q, araddr_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic [3:0]  awaddr_q, awaddr_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bready_q, bready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_ack_q, rx_ack_d;
  logic        tx_ack_q, tx_ack_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  tx_byte;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        unused_rdata_hi;

  assign ar_hs = arvalid_q & uart_axi.arready;
  assign r_hs  = rready_q  & uart_axi.rvalid;
  assign aw_hs = awvalid_q & uart_axi.awready;
  assign w_hs  = wvalid_q  & uart_axi.wready;
  assign b_hs  = bready_q  & uart_axi.bvalid;
  assign unused_rdata_hi = ^uart_axi.rdata[31:8];

`ifdef UART_SCHED_WORD_EN
  logic [1:0] byte_q, byte_d;

  always_comb begin
    tx_byte = tx_data[7:0];
    case (byte_q)
      2'd1:    tx_byte = tx_data[15:8];
      2'd2:    tx_byte = tx_data[23:16];
      2'd3:    tx_byte = tx_data[31:24];
      default: tx_byte = tx_data[7:0];
    endcase
  end
`else
  assign tx_byte = tx_data;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bready_d     = bready_q;
    rx_data_d    = rx_data_q;
    rx_ack_d     = 1'b0;
    tx_ack_d     = 1'b0;
`ifdef UART_SCHED_WORD_EN
    byte_d       = byte_q;
`endif
    // Error responses are recorded but never abort the sequence.
    err_d = err_q | (r_hs & (|uart_axi.rresp)) | (b_hs & (|uart_axi.bresp));

    case (state_q)
      IDLE: begin
        // No grant in the ack cycle: the client has not yet had a chance to drop its request.
        if (!rx_ack_q && !tx_ack_q && (rx_req || tx_req)) begin
          grant_d      = (rx_req && tx_req) ? ~last_grant_q : tx_req;
          last_grant_d = grant_d;
          arvalid_d    = 1'b1;
          araddr_d     = ADDR_STAT;
          state_d      = ST_AR;
        end
      end
      ST_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (r_hs) begin
          rready_d = 1'b0;
          if (grant_q == GNT_RX && uart_axi.rdata[0]) begin
            arvalid_d = 1'b1;
            araddr_d  = ADDR_RX;
            state_d   = RX_AR;
          end else if (grant_q == GNT_TX && !uart_axi.rdata[3]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = ADDR_TX;
            wdata_d   = {24'b0, tx_byte};
            wstrb_d   = 4'b0001;
            state_d   = TX_W;
          end else if (POLL_GAP == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (gap_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      RX_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RX_R;
        end
      end
      RX_R: begin
        if (r_hs) begin
          rready_d  = 1'b0;
          rx_data_d = uart_axi.rdata[7:0];
          rx_ack_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      TX_W: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // Address and data channels may complete in either order or together.
        if ((!awvalid_q || uart_axi.awready) && (!wvalid_q || uart_axi.wready)) begin
          bready_d = 1'b1;
          state_d  = TX_B;
        end
      end
      TX_B: begin
        if (b_hs) begin
          bready_d = 1'b0;
`ifdef UART_SCHED_WORD_EN
          if (byte_q == 2'd3) begin
            byte_d   = 2'd0;
            tx_ack_d = 1'b1;
            state_d  = IDLE;
          end else begin
            byte_d    = byte_q + 2'd1;
            arvalid_d = 1'b1;
            araddr_d  = ADDR_STAT;
            state_d   = ST_AR;
          end
`else
          tx_ack_d = 1'b1;
          state_d  = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= GNT_RX;
      last_grant_q <= GNT_TX;
      gap_q        <= 8'd0;
      arvalid_q    <= 1'b0;
      araddr_q     <= ADDR_STAT;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= ADDR_TX;
      wvalid_q     <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      bready_q     <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_ack_q     <= 1'b0;
      tx_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef UART_SCHED_WORD_EN
      byte_q       <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bready_q     <= bready_d;
      rx_data_q    <= rx_data_d;
      rx_ack_q     <= rx_ack_d;
      tx_ack_q     <= tx_ack_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
`ifdef UART_SCHED_WORD_EN
      byte_q       <= byte_d;
`endif
    end
  end

  assign uart_axi.arvalid = arvalid_q;
  assign uart_axi.araddr  = araddr_q;
  assign uart_axi.rready  = rready_q;
  assign uart_axi.awvalid = awvalid_q;
  assign uart_axi.awaddr  = awaddr_q;
  assign uart_axi.wvalid  = wvalid_q;
  assign uart_axi.wdata   = wdata_q;
  assign uart_axi.wstrb   = wstrb_q;
  assign uart_axi.bready  = bready_q;
  assign rx_data          = rx_data_q;
  assign rx_ack           = rx_ack_q;
  assign tx_ack           = tx_ack_q;
  assign busy             = busy_q;
  assign err              = err_q;

endmodule
